// File: rtl/imm_encoder_if.sv
// Request/delivery handshake bundle for imm_encoder: request fields in,
// encoded words and statistics out.
interface imm_encoder_if #(
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [6:0]       opcode;
    logic [4:0]       rd;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [2:0]       funct3;
    logic [63:0]      imm;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_instr;
    logic             out_err;
    logic [CNT_W-1:0] enc_count;
    logic [CNT_W-1:0] err_count;

    modport master (
        output in_valid, opcode, rd, rs1, rs2, funct3, imm, out_ready,
        input  in_ready, out_valid, out_instr, out_err, enc_count, err_count
    );

    modport slave (
        input  in_valid, opcode, rd, rs1, rs2, funct3, imm, out_ready,
        output in_ready, out_valid, out_instr, out_err, enc_count, err_count
    );
endinterface

// File: rtl/imm_encoder.sv
// Packs I/S/SB-type RV64 instruction words from fields plus a signed immediate,
// buffers them with a range-error flag in a small FIFO and counts deliveries.
module imm_encoder #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input logic          clk,
    input logic          reset_n,
    imm_encoder_if.slave bus
);
    localparam int          AW   = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    logic [32:0]      r_mem [DEPTH];
    logic [AW-1:0]    r_wrPtr;
    logic [AW-1:0]    r_rdPtr;
    logic [AW:0]      r_count;
    logic [CNT_W-1:0] r_encCount;
    logic [CNT_W-1:0] r_errCount;

    logic [11:0] w_imm12;
    logic        w_rangeErr;
    logic [31:0] w_instr;
    logic        w_push;
    logic        w_pop;

    // Anything outside the signed 12-bit window is still encoded (truncated) but flagged.
    assign w_imm12    = bus.imm[11:0];
    assign w_rangeErr = !((&bus.imm[63:11]) || !(|bus.imm[63:11]));

    always_comb begin
        w_instr = {w_imm12, bus.rs1, bus.funct3, bus.rd, bus.opcode};
        if (bus.opcode[6]) begin
            w_instr = {w_imm12[11], w_imm12[9:4], bus.rs2, bus.rs1, bus.funct3,
                       w_imm12[3:0], w_imm12[10], bus.opcode};
        end else if (bus.opcode[5]) begin
            w_instr = {w_imm12[11:5], bus.rs2, bus.rs1, bus.funct3, w_imm12[4:0], bus.opcode};
        end
    end

    assign bus.in_ready  = (r_count != FULL);
    assign bus.out_valid = (r_count != '0);
    assign w_push        = bus.in_valid && bus.in_ready;
    assign w_pop         = bus.out_valid && bus.out_ready;

    assign {bus.out_err, bus.out_instr} = r_mem[r_rdPtr];
    assign bus.enc_count = r_encCount;
    assign bus.err_count = r_errCount;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= {w_rangeErr, w_instr};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + AW'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW + 1)'(1);
                2'b01:   r_count <= r_count - (AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Delivery count wraps; error count sticks at all-ones.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_encCount <= '0;
            r_errCount <= '0;
        end else if (w_pop) begin
            r_encCount <= r_encCount + CNT_W'(1);
            if (bus.out_err && (r_errCount != '1)) begin
                r_errCount <= r_errCount + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_imm_encoder.sv
// Bench for imm_encoder: directed vector table, multi-cycle corner sequences and
// randomized traffic scored against a queue-based reference model.
module tb_imm_encoder;
    localparam int DEPTH = 2;
    localparam int CNT_W = 16;

    typedef struct {
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [63:0] imm;
        logic [31:0] expInstr;
        logic        expErr;
    } vec_t;

    typedef struct packed {
        logic        err;
        logic [31:0] instr;
    } ent_t;

    logic clk;
    logic reset_n;
    int   nChecks;
    int   nFails;

    ent_t             q[$];
    logic [CNT_W-1:0] encModel;
    logic [CNT_W-1:0] errModel;
    vec_t             vecs[8];

    imm_encoder_if #(.CNT_W(CNT_W)) bus ();

    imm_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference encoder built from field weights with plain arithmetic.
    function automatic ent_t encodeRef(input logic [6:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2,
                                       input logic [2:0] f3, input logic [63:0] imm);
        longint      s;
        int unsigned u;
        int unsigned body;
        int unsigned w;
        ent_t        e;
        s    = $signed(imm);
        u    = 32'(imm % 64'd4096);
        body = int'(rs1) * 32768 + int'(f3) * 4096 + int'(op);
        if (op >= 7'd64) begin
            w = (u / 2048) * 32'h8000_0000 + ((u / 16) % 64) * 32'h0200_0000
              + int'(rs2) * 32'h0010_0000 + body + (u % 16) * 256 + ((u / 1024) % 2) * 128;
        end else if (op >= 7'd32) begin
            w = (u / 32) * 32'h0200_0000 + int'(rs2) * 32'h0010_0000 + body + (u % 32) * 128;
        end else begin
            w = u * 32'h0010_0000 + body + int'(rd) * 128;
        end
        e.instr = w;
        e.err   = (s < -2048) || (s > 2047);
        return e;
    endfunction

    // Immediate extractor of the core, used for round-trip checks.
    function automatic longint extractRef(input logic [31:0] w);
        logic [11:0] f;
        if (w[6]) begin
            f = {w[31], w[7], w[30:25], w[11:8]};
        end else if (w[5]) begin
            f = {w[31:25], w[11:7]};
        end else begin
            f = w[31:20];
        end
        return longint'($signed(f));
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input logic valid);
        bus.in_valid = valid;
        bus.opcode   = v.opcode;
        bus.rd       = v.rd;
        bus.rs1      = v.rs1;
        bus.rs2      = v.rs2;
        bus.funct3   = v.f3;
        bus.imm      = v.imm;
    endtask

    // Advance one clock, updating the reference model from the pre-edge inputs.
    task automatic tick();
        logic doPush;
        logic doPop;
        logic doReset;
        ent_t e;
        ent_t popped;
        doReset = !reset_n;
        doPush  = bus.in_valid && (q.size() < DEPTH);
        doPop   = (q.size() > 0) && bus.out_ready;
        e       = encodeRef(bus.opcode, bus.rd, bus.rs1, bus.rs2, bus.funct3, bus.imm);
        @(posedge clk);
        #1;
        if (doReset) begin
            q.delete();
            encModel = '0;
            errModel = '0;
        end else begin
            if (doPop) begin
                popped   = q.pop_front();
                encModel = encModel + 1'b1;
                if (popped.err && (errModel != '1)) errModel = errModel + 1'b1;
            end
            if (doPush) q.push_back(e);
        end
    endtask

    task automatic checkModel(input string tag);
        checkOutput({tag, "_out_valid"}, 64'(bus.out_valid), 64'(q.size() != 0));
        checkOutput({tag, "_in_ready"}, 64'(bus.in_ready), 64'(q.size() < DEPTH));
        checkOutput({tag, "_enc_count"}, 64'(bus.enc_count), 64'(encModel));
        checkOutput({tag, "_err_count"}, 64'(bus.err_count), 64'(errModel));
        if (q.size() != 0) begin
            checkOutput({tag, "_out_instr"}, 64'(bus.out_instr), 64'(q[0].instr));
            checkOutput({tag, "_out_err"}, 64'(bus.out_err), 64'(q[0].err));
        end
    endtask

    initial begin
        vec_t v;
        nChecks       = 0;
        nFails        = 0;
        encModel      = '0;
        errModel      = '0;
        reset_n       = 1'b0;
        bus.out_ready = 1'b0;

        vecs[0] = '{7'h03, 5'd5, 5'd2, 5'd0,  3'd3, 64'd8,     32'h00813283, 1'b0};
        vecs[1] = '{7'h23, 5'd9, 5'd2, 5'd5,  3'd3, 64'd16,    32'h00513823, 1'b0};
        vecs[2] = '{7'h63, 5'd0, 5'd1, 5'd2,  3'd0, -64'd2,    32'hFE208EE3, 1'b0};
        vecs[3] = '{7'h03, 5'd5, 5'd2, 5'd0,  3'd3, 64'd2048,  32'h80013283, 1'b1};
        vecs[4] = '{7'h03, 5'd5, 5'd2, 5'd0,  3'd3, -64'd2048, 32'h80013283, 1'b0};
        vecs[5] = '{7'h63, 5'd0, 5'd1, 5'd2,  3'd0, 64'd2047,  32'h7E208FE3, 1'b0};
        vecs[6] = '{7'h23, 5'd0, 5'd2, 5'd5,  3'd3, -64'd1,    32'hFE513FA3, 1'b0};
        vecs[7] = '{7'h63, 5'd0, 5'd1, 5'd2,  3'd0, -64'd4096, 32'h00208063, 1'b1};
        applyStimulus(vecs[0], 1'b0);

        @(posedge clk);
        #1;
        tick();
        tick();
        reset_n = 1'b1;
        checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("rst_in_ready", 64'(bus.in_ready), 64'd1);
        checkOutput("rst_enc_count", 64'(bus.enc_count), 64'd0);
        checkOutput("rst_err_count", 64'(bus.err_count), 64'd0);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i], 1'b1);
            tick();
            bus.in_valid = 1'b0;
            checkOutput($sformatf("vec%0d_valid", i), 64'(bus.out_valid), 64'd1);
            checkOutput($sformatf("vec%0d_instr", i), 64'(bus.out_instr), 64'(vecs[i].expInstr));
            checkOutput($sformatf("vec%0d_err", i), 64'(bus.out_err), 64'(vecs[i].expErr));
            if (!vecs[i].expErr) begin
                checkOutput($sformatf("vec%0d_roundtrip", i),
                            64'(extractRef(bus.out_instr)), vecs[i].imm);
            end
            bus.out_ready = 1'b1;
            tick();
            bus.out_ready = 1'b0;
            checkModel($sformatf("vec%0d_post", i));
            if (i == 0) checkOutput("vec0_enc_count", 64'(bus.enc_count), 64'd1);
            if (i == 3) checkOutput("vec3_err_count", 64'(bus.err_count), 64'd1);
        end

        // Backpressure: four offers against a stalled consumer, only two fit.
        v = '{7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 64'd0, 32'd0, 1'b0};
        for (int k = 1; k <= 4; k++) begin
            v.imm = 64'(k);
            applyStimulus(v, 1'b1);
            tick();
            checkModel($sformatf("bp%0d", k));
        end
        bus.in_valid = 1'b0;
        checkOutput("bp_in_ready", 64'(bus.in_ready), 64'd0);
        checkOutput("bp_head_hold", 64'(bus.out_instr[31:20]), 64'd1);
        bus.out_ready = 1'b1;
        checkOutput("bp_first", 64'(bus.out_instr[31:20]), 64'd1);
        tick();
        checkOutput("bp_second", 64'(bus.out_instr[31:20]), 64'd2);
        tick();
        checkOutput("bp_drained", 64'(bus.out_valid), 64'd0);
        bus.out_ready = 1'b0;

        // Reset while full and stalled must discard everything in flight.
        applyStimulus(vecs[0], 1'b1);
        tick();
        tick();
        bus.in_valid = 1'b0;
        checkOutput("mid_full", 64'(bus.in_ready), 64'd0);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        checkOutput("mid_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("mid_in_ready", 64'(bus.in_ready), 64'd1);
        checkOutput("mid_enc_count", 64'(bus.enc_count), 64'd0);
        checkOutput("mid_err_count", 64'(bus.err_count), 64'd0);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput("mid_no_stale", 64'(bus.out_valid), 64'd0);
        end

        // Randomized traffic against the reference model.
        for (int n = 0; n < 400; n++) begin
            v.opcode = 7'($urandom_range(0, 127));
            v.rd     = 5'($urandom);
            v.rs1    = 5'($urandom);
            v.rs2    = 5'($urandom);
            v.f3     = 3'($urandom);
            case ($urandom_range(0, 2))
                0:       v.imm = 64'(longint'($urandom_range(0, 4095)) - 64'sd2048);
                1: begin
                    case ($urandom_range(0, 3))
                        0:       v.imm = -64'd2049;
                        1:       v.imm = -64'd2048;
                        2:       v.imm = 64'd2047;
                        default: v.imm = 64'd2048;
                    endcase
                end
                default: v.imm = {$urandom, $urandom};
            endcase
            applyStimulus(v, 1'($urandom_range(0, 1)));
            bus.out_ready = 1'($urandom_range(0, 2) != 0);
            reset_n       = ($urandom_range(0, 79) != 0);
            tick();
            checkModel($sformatf("rnd%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
